// File: rtl/lsu_subword_rmw_if.sv
// Signal bundle between the EX/MEM register, DataMemory and the sub-word
// load/store alignment stage. The slave modport is the alignment stage's view.
interface lsu_subword_rmw_if #(
    parameter int COUNT_WIDTH = 16
);
    logic [31:0]            EX_MEM_Address;
    logic [31:0]            EX_MEM_WriteData;
    logic                   EX_MEM_MemWrite;
    logic                   EX_MEM_MemRead;
    logic                   EX_MEM_HalfControl;
    logic                   EX_MEM_ByteControl;
    logic [31:0]            MEM_ReadData;

    logic [31:0]            Mem_Address;
    logic [31:0]            Mem_WriteData;
    logic                   Mem_MemWrite;
    logic [31:0]            MEM_LoadData;
    logic                   MEM_Stall;
    logic                   MEM_Misaligned;
    logic                   MisalignedSticky;
    logic [COUNT_WIDTH-1:0] SubwordStoreCount;

    modport slave (
        input  EX_MEM_Address,
        input  EX_MEM_WriteData,
        input  EX_MEM_MemWrite,
        input  EX_MEM_MemRead,
        input  EX_MEM_HalfControl,
        input  EX_MEM_ByteControl,
        input  MEM_ReadData,
        output Mem_Address,
        output Mem_WriteData,
        output Mem_MemWrite,
        output MEM_LoadData,
        output MEM_Stall,
        output MEM_Misaligned,
        output MisalignedSticky,
        output SubwordStoreCount
    );

    modport master (
        output EX_MEM_Address,
        output EX_MEM_WriteData,
        output EX_MEM_MemWrite,
        output EX_MEM_MemRead,
        output EX_MEM_HalfControl,
        output EX_MEM_ByteControl,
        output MEM_ReadData,
        input  Mem_Address,
        input  Mem_WriteData,
        input  Mem_MemWrite,
        input  MEM_LoadData,
        input  MEM_Stall,
        input  MEM_Misaligned,
        input  MisalignedSticky,
        input  SubwordStoreCount
    );
endinterface

// File: rtl/lsu_subword_rmw.sv
// Load/store alignment stage in front of a word-write-only, falling-edge BRAM:
// sub-word stores become read-modify-write, sub-word loads are extracted and sign-extended.
module lsu_subword_rmw #(
    parameter bit MISALIGN_SUPPRESS = 1'b1,
    parameter int COUNT_WIDTH       = 16
) (
    input  logic             Clk,
    input  logic             Reset,
    lsu_subword_rmw_if.slave bus
);

    typedef enum logic {
        IDLE  = 1'b0,
        MERGE = 1'b1
    } state_t;

    state_t                 state_q;
    state_t                 state_d;
    logic [31:0]            mergeWord_q;
    logic [31:0]            mergeWord_d;
    logic                   misalignedSticky_q;
    logic                   misalignedSticky_d;
    logic [COUNT_WIDTH-1:0] storeCount_q;
    logic [COUNT_WIDTH-1:0] storeCount_d;

    logic [1:0]             offset;
    logic                   isHalf;
    logic                   isByte;
    logic                   isWord;
    logic                   isAccess;
    logic                   isStore;
    logic                   isLoad;
    logic                   misaligned;
    logic                   suppress;
    logic [4:0]             byteShift;
    logic [7:0]             loadByte;
    logic [15:0]            loadHalf;
    logic [31:0]            loadData;
    logic [31:0]            mergedWord;
    logic [31:0]            memWriteData;
    logic                   memWrite;
    logic                   stall;
    logic                   capture;
    logic                   storeDone;

    assign offset     = bus.EX_MEM_Address[1:0];
    assign isHalf     = bus.EX_MEM_HalfControl;
    assign isByte     = bus.EX_MEM_ByteControl & ~bus.EX_MEM_HalfControl;
    assign isWord     = ~bus.EX_MEM_HalfControl & ~bus.EX_MEM_ByteControl;
    assign isAccess   = bus.EX_MEM_MemRead | bus.EX_MEM_MemWrite;
    assign isStore    = bus.EX_MEM_MemWrite;
    assign isLoad     = bus.EX_MEM_MemRead & ~bus.EX_MEM_MemWrite;
    assign misaligned = isAccess & ((isWord & (offset != 2'b00)) | (isHalf & offset[0]));
    assign suppress   = misaligned & MISALIGN_SUPPRESS;

    // Byte lanes are little-endian; a misaligned half still picks the half named by Address[1].
    assign byteShift  = {offset, 3'b000};
    assign loadByte   = bus.MEM_ReadData[byteShift +: 8];
    assign loadHalf   = offset[1] ? bus.MEM_ReadData[31:16] : bus.MEM_ReadData[15:0];

    always_comb begin
        loadData = '0;
        if (isLoad) begin
            if (isHalf) begin
                loadData = {{16{loadHalf[15]}}, loadHalf};
            end else if (isByte) begin
                loadData = {{24{loadByte[7]}}, loadByte};
            end else begin
                loadData = bus.MEM_ReadData;
            end
        end
    end

    always_comb begin
        mergedWord = mergeWord_q;
        if (isHalf) begin
            if (offset[1]) begin
                mergedWord[31:16] = bus.EX_MEM_WriteData[15:0];
            end else begin
                mergedWord[15:0] = bus.EX_MEM_WriteData[15:0];
            end
        end else begin
            mergedWord[byteShift +: 8] = bus.EX_MEM_WriteData[7:0];
        end
    end

    // IDLE handles word stores directly and opens the read cycle for sub-word stores.
    always_comb begin
        state_d      = state_q;
        memWrite     = 1'b0;
        memWriteData = bus.EX_MEM_WriteData;
        stall        = 1'b0;
        capture      = 1'b0;
        storeDone    = 1'b0;
        case (state_q)
            IDLE: begin
                if (isStore && !suppress) begin
                    if (isWord) begin
                        memWrite = 1'b1;
                    end else begin
                        stall   = 1'b1;
                        capture = 1'b1;
                        state_d = MERGE;
                    end
                end
            end
            MERGE: begin
                memWriteData = mergedWord;
                memWrite     = 1'b1;
                storeDone    = 1'b1;
                state_d      = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        if (Reset) begin
            memWrite = 1'b0;
            stall    = 1'b0;
        end
    end

    always_comb begin
        mergeWord_d        = capture ? bus.MEM_ReadData : mergeWord_q;
        misalignedSticky_d = misalignedSticky_q | misaligned;
        storeCount_d       = storeCount_q;
        if (storeDone) begin
            storeCount_d = storeCount_q + COUNT_WIDTH'(1);
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q            <= IDLE;
            mergeWord_q        <= '0;
            misalignedSticky_q <= 1'b0;
            storeCount_q       <= '0;
        end else begin
            state_q            <= state_d;
            mergeWord_q        <= mergeWord_d;
            misalignedSticky_q <= misalignedSticky_d;
            storeCount_q       <= storeCount_d;
        end
    end

    assign bus.Mem_Address       = {bus.EX_MEM_Address[31:2], 2'b00};
    assign bus.Mem_WriteData     = memWriteData;
    assign bus.Mem_MemWrite      = memWrite;
    assign bus.MEM_LoadData      = loadData;
    assign bus.MEM_Stall         = stall;
    assign bus.MEM_Misaligned    = misaligned;
    assign bus.MisalignedSticky  = misalignedSticky_q;
    assign bus.SubwordStoreCount = storeCount_q;

endmodule

// File: tb/tb_lsu_subword_rmw.sv
// Scoreboard bench for lsu_subword_rmw with a falling-edge, write-first BRAM model;
// the driver queues one expected record per cycle and the monitor checks it late in the cycle.
module tb_lsu_subword_rmw;

    logic Clk = 1'b0;
    logic Reset;

    lsu_subword_rmw_if #(.COUNT_WIDTH(16)) bus ();

    lsu_subword_rmw #(
        .MISALIGN_SUPPRESS(1'b1),
        .COUNT_WIDTH      (16)
    ) dut (
        .Clk  (Clk),
        .Reset(Reset),
        .bus  (bus)
    );

    always #5 Clk = ~Clk;

    typedef struct {
        string       tag;
        logic [31:0] expAddr;
        logic        expWe;
        logic        chkWd;
        logic [31:0] expWd;
        logic        expStall;
        logic        expMis;
        logic        chkLd;
        logic [31:0] expLd;
        logic        chkStat;
        logic        expSticky;
        logic [15:0] expCount;
    } exp_t;

    exp_t        expQ[$];
    int          compareCount  = 0;
    int          mismatchCount = 0;
    logic [31:0] mem [0:63];

    localparam logic [31:0] LD_ADDR [7] = '{32'h53, 32'h50, 32'h51, 32'h52, 32'h52, 32'h50, 32'h50};
    localparam int          LD_SIZE [7] = '{0, 0, 0, 0, 1, 1, 2};
    localparam logic [31:0] LD_EXP  [7] = '{32'hFFFFFF80, 32'h00000001, 32'h0000007F, 32'hFFFFFFFF,
                                            32'hFFFF80FF, 32'h00007F01, 32'h80FF7F01};

    // DataMemory: reads and writes on the falling edge, write-first on a same-word write.
    always @(negedge Clk) begin
        if (bus.Mem_MemWrite === 1'b1) begin
            mem[bus.Mem_Address[7:2]] = bus.Mem_WriteData;
            bus.MEM_ReadData <= bus.Mem_WriteData;
        end else begin
            bus.MEM_ReadData <= mem[bus.Mem_Address[7:2]];
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] required);
        compareCount++;
        if (actual !== required) begin
            mismatchCount++;
            $display("[TB] FAIL %s actual=0x%08h required=0x%08h", name, actual, required);
        end
    endtask

    function automatic exp_t mk(input string tag, input int we, input int chkWd, input logic [31:0] wd,
                                input int stall, input int mis, input int chkLd, input logic [31:0] ld,
                                input int chkStat, input int sticky, input int cnt);
        exp_t e;
        e.tag       = tag;
        e.expAddr   = '0;
        e.expWe     = 1'(we);
        e.chkWd     = 1'(chkWd);
        e.expWd     = wd;
        e.expStall  = 1'(stall);
        e.expMis    = 1'(mis);
        e.chkLd     = 1'(chkLd);
        e.expLd     = ld;
        e.chkStat   = 1'(chkStat);
        e.expSticky = 1'(sticky);
        e.expCount  = 16'(cnt);
        return e;
    endfunction

    task automatic applyStimulus(input logic [31:0] addr, input logic [31:0] wd, input int we, input int re,
                                 input int hc, input int bc, input int rst, input exp_t e);
        exp_t q;
        Reset                  = 1'(rst);
        bus.EX_MEM_Address     = addr;
        bus.EX_MEM_WriteData   = wd;
        bus.EX_MEM_MemWrite    = 1'(we);
        bus.EX_MEM_MemRead     = 1'(re);
        bus.EX_MEM_HalfControl = 1'(hc);
        bus.EX_MEM_ByteControl = 1'(bc);
        q         = e;
        q.expAddr = {addr[31:2], 2'b00};
        expQ.push_back(q);
        @(posedge Clk);
        #1;
    endtask

    // Monitor: sample just before the next rising edge, after the BRAM read has settled.
    always @(negedge Clk) begin
        exp_t e;
        #2;
        if (expQ.size() > 0) begin
            e = expQ.pop_front();
            checkOutput({e.tag, ".addr"}, bus.Mem_Address, e.expAddr);
            checkOutput({e.tag, ".we"}, {31'b0, bus.Mem_MemWrite}, {31'b0, e.expWe});
            checkOutput({e.tag, ".stall"}, {31'b0, bus.MEM_Stall}, {31'b0, e.expStall});
            checkOutput({e.tag, ".mis"}, {31'b0, bus.MEM_Misaligned}, {31'b0, e.expMis});
            if (e.chkWd) begin
                checkOutput({e.tag, ".wdata"}, bus.Mem_WriteData, e.expWd);
            end
            if (e.chkLd) begin
                checkOutput({e.tag, ".load"}, bus.MEM_LoadData, e.expLd);
            end
            if (e.chkStat) begin
                checkOutput({e.tag, ".sticky"}, {31'b0, bus.MisalignedSticky}, {31'b0, e.expSticky});
                checkOutput({e.tag, ".count"}, {16'b0, bus.SubwordStoreCount}, {16'b0, e.expCount});
            end
        end
    end

    initial begin
        for (int i = 0; i < 64; i++) begin
            mem[i] = 32'h0;
        end
        mem[16] = 32'h11223344;
        mem[18] = 32'h00000000;
        mem[19] = 32'h55667788;
        mem[20] = 32'h80FF7F01;

        Reset                  = 1'b1;
        bus.EX_MEM_Address     = '0;
        bus.EX_MEM_WriteData   = '0;
        bus.EX_MEM_MemWrite    = 1'b0;
        bus.EX_MEM_MemRead     = 1'b0;
        bus.EX_MEM_HalfControl = 1'b0;
        bus.EX_MEM_ByteControl = 1'b0;
        @(posedge Clk);
        @(posedge Clk);
        #1;

        // Store request while Reset is high must neither write nor stall.
        applyStimulus(32'h41, 32'hAB, 1, 0, 0, 1, 1, mk("rst_comb", 0, 0, 0, 0, 0, 1, 0, 1, 0, 0));
        applyStimulus(32'h0, 32'h0, 0, 0, 0, 0, 0, mk("idle0", 0, 0, 0, 0, 0, 1, 0, 1, 0, 0));

        applyStimulus(32'h41, 32'hAB, 1, 0, 0, 1, 0, mk("sb_read", 0, 0, 0, 1, 0, 1, 0, 1, 0, 0));
        applyStimulus(32'h41, 32'hAB, 1, 0, 0, 1, 0, mk("sb_merge", 1, 1, 32'h1122AB44, 0, 0, 1, 0, 1, 0, 0));
        checkOutput("sb_mem", mem[16], 32'h1122AB44);
        mem[16] = 32'h11223344;

        applyStimulus(32'h42, 32'hBEEF, 1, 0, 1, 0, 0, mk("sh_read", 0, 0, 0, 1, 0, 1, 0, 1, 0, 1));
        applyStimulus(32'h42, 32'hBEEF, 1, 0, 1, 0, 0, mk("sh_merge", 1, 1, 32'hBEEF3344, 0, 0, 1, 0, 1, 0, 1));
        applyStimulus(32'h40, 32'h0, 0, 1, 0, 0, 0, mk("lw_after_sh", 0, 0, 0, 0, 0, 1, 32'hBEEF3344, 1, 0, 2));

        for (int i = 0; i < 7; i++) begin
            applyStimulus(LD_ADDR[i], 32'h0, 0, 1, int'(LD_SIZE[i] == 1), int'(LD_SIZE[i] == 0), 0,
                          mk($sformatf("load_%0d", i), 0, 0, 0, 0, 0, 1, LD_EXP[i], 1, 0, 2));
        end

        applyStimulus(32'h44, 32'hCAFEF00D, 1, 0, 0, 0, 0, mk("sw", 1, 1, 32'hCAFEF00D, 0, 0, 1, 0, 1, 0, 2));
        applyStimulus(32'h45, 32'h1234, 1, 0, 1, 0, 0, mk("sh_mis", 0, 0, 0, 0, 1, 1, 0, 1, 0, 2));
        applyStimulus(32'h53, 32'h0, 0, 1, 1, 0, 0, mk("lh_mis", 0, 0, 0, 0, 1, 1, 32'hFFFF80FF, 1, 1, 2));
        checkOutput("sw_mem", mem[17], 32'hCAFEF00D);
        applyStimulus(32'h52, 32'h0, 0, 1, 0, 0, 0, mk("lw_mis", 0, 0, 0, 0, 1, 1, 32'h80FF7F01, 1, 1, 2));

        // Back-to-back byte stores; the second also has MemRead set and must act as a store.
        applyStimulus(32'h48, 32'h12345601, 1, 0, 0, 1, 0, mk("bb1_read", 0, 0, 0, 1, 0, 1, 0, 1, 1, 2));
        applyStimulus(32'h48, 32'h12345601, 1, 0, 0, 1, 0, mk("bb1_merge", 1, 1, 32'h00000001, 0, 0, 1, 0, 1, 1, 2));
        applyStimulus(32'h4B, 32'hFFFFFF02, 1, 1, 0, 1, 0, mk("bb2_read", 0, 0, 0, 1, 0, 1, 0, 1, 1, 3));
        applyStimulus(32'h4B, 32'hFFFFFF02, 1, 1, 0, 1, 0, mk("bb2_merge", 1, 1, 32'h02000001, 0, 0, 1, 0, 1, 1, 3));
        applyStimulus(32'h0, 32'h0, 0, 0, 0, 0, 0, mk("bb_done", 0, 0, 0, 0, 0, 1, 0, 1, 1, 4));
        checkOutput("bb_mem", mem[18], 32'h02000001);

        applyStimulus(32'h4C, 32'h99, 1, 0, 0, 1, 0, mk("rst_read", 0, 0, 0, 1, 0, 1, 0, 1, 1, 4));
        applyStimulus(32'h4C, 32'h99, 1, 0, 0, 1, 1, mk("rst_merge", 0, 0, 0, 0, 0, 1, 0, 1, 1, 4));
        applyStimulus(32'h4C, 32'h99, 1, 0, 0, 1, 0, mk("post_rst_read", 0, 0, 0, 1, 0, 1, 0, 1, 0, 0));
        checkOutput("rst_mem", mem[19], 32'h55667788);
        applyStimulus(32'h4C, 32'h99, 1, 0, 0, 1, 0, mk("post_rst_merge", 1, 1, 32'h55667799, 0, 0, 1, 0, 1, 0, 0));
        applyStimulus(32'h0, 32'h0, 0, 0, 0, 0, 0, mk("final", 0, 0, 0, 0, 0, 1, 0, 1, 0, 1));

        for (int i = 0; i < 20 && expQ.size() > 0; i++) begin
            @(posedge Clk);
        end
        if (expQ.size() > 0) begin
            checkOutput("scoreboard_drain", 32'(expQ.size()), 32'h0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, mismatchCount);
        $finish;
    end

endmodule

// File: doc/lsu_subword_rmw.md
Name: lsu_subword_rmw

Overview:
Load/store alignment stage between the EX/MEM pipeline register and DataMemory. DataMemory is a 32-bit, word-write-only BRAM clocked on the falling edge, so this block does the byte/half work around it.
- Byte and half-word stores become a two-cycle read-modify-write, with a pipeline stall during the read cycle.
- Byte and half-word loads are extracted from the raw read word and sign-extended before MEM/WB.
- Word accesses pass through in one cycle.

Parameters:
MISALIGN_SUPPRESS, 1, when 1 a misaligned store never asserts Mem_MemWrite; when 0 the address is force-aligned and the store proceeds.
COUNT_WIDTH, 16, width of the sub-word store performance counter.

Ports:
Clk  input  1  pipeline clock; all state updates on posedge.
Reset  input  1  synchronous, active-high reset.
EX_MEM_Address  input  32  byte address from EX/MEM.
EX_MEM_WriteData  input  32  store data; byte stores use [7:0], half stores use [15:0].
EX_MEM_MemWrite  input  1  store request.
EX_MEM_MemRead  input  1  load request.
EX_MEM_HalfControl  input  1  half-word access.
EX_MEM_ByteControl  input  1  byte access; HalfControl has priority if both are set.
MEM_ReadData  input  32  raw word returned by DataMemory.
Mem_Address  output  32  address to DataMemory, always {EX_MEM_Address[31:2],2'b00}.
Mem_WriteData  output  32  full word to DataMemory.
Mem_MemWrite  output  1  write enable to DataMemory.
MEM_LoadData  output  32  aligned, sign-extended load result to MEM/WB.
MEM_Stall  output  1  freezes PC, IF/ID, ID/EX and EX/MEM while high.
MEM_Misaligned  output  1  combinational flag for the current access.
MisalignedSticky  output  1  set on any flagged access; cleared only by Reset.
SubwordStoreCount  output  COUNT_WIDTH  number of completed sub-word stores; wraps at 2^COUNT_WIDTH.

Behaviour:
- Reset values: state=IDLE, merge register=0, MisalignedSticky=0, SubwordStoreCount=0.
- While Reset is high, Mem_MemWrite=0 and MEM_Stall=0 combinationally.
- Byte lanes are little-endian: Address[1:0]=00 selects bits 7:0, 01 selects 15:8, 10 selects 23:16, 11 selects 31:24. Half-word Address[1]=0 selects 15:0, Address[1]=1 selects 31:16.
- Misaligned: a word access with Address[1:0]!=00, or a half-word access with Address[0]=1. MEM_Misaligned is only asserted when MemRead or MemWrite is set.
- Loads:
  - Combinational from MEM_ReadData, zero added latency.
  - Byte loads sign-extend from bit 7 of the selected byte; half loads from bit 15 of the selected half; word loads pass through.
  - A misaligned load returns the aligned word (word) or the aligned half (half) and sets the flag.
  - MEM_LoadData=0 when MemRead=0.
- FSM, two states:
  - IDLE:
    - Word store: Mem_MemWrite=EX_MEM_MemWrite, Mem_WriteData=EX_MEM_WriteData, no stall.
    - Sub-word store (aligned, or MISALIGN_SUPPRESS=0): MEM_Stall=1, Mem_MemWrite=0. At posedge, capture MEM_ReadData into the merge register (valid, since the BRAM reads on the preceding negedge) and go to MERGE.
    - Otherwise remain in IDLE.
  - MERGE:
    - Mem_WriteData = merge register with only the selected lane replaced; Mem_MemWrite=1; MEM_Stall=0.
    - At posedge, SubwordStoreCount increments and state returns to IDLE unconditionally.
- EX_MEM inputs are stable throughout the stall because this block's stall holds the register.
- Back-to-back sub-word stores take 2 cycles each; each one re-enters the read cycle from IDLE.
- A load that follows a store to the same word sees the new data, because the BRAM is WRITE_FIRST and the write happens one cycle earlier.
- Misaligned store with MISALIGN_SUPPRESS=1: Mem_MemWrite=0, no stall, MisalignedSticky set at posedge.
- Reset asserted during MERGE: no write occurs, and state is IDLE after the edge. Reset asserted during the IDLE read cycle: no capture takes place.
- If MemRead and MemWrite are both set, the access is treated as a store, and MEM_LoadData=0.

Test Plan:
- Word at 0x40=0x11223344; sb of 0xAB to 0x41. Required: cycle1 MEM_Stall=1 and Mem_MemWrite=0; cycle2 Mem_MemWrite=1 and Mem_WriteData=0x1122AB44; SubwordStoreCount=1.
- Same word; sh of 0xBEEF to 0x42. Required: two cycles, write of 0xBEEF3344; a following lw from 0x40 returns 0xBEEF3344.
- Word 0x80FF7F01. Required: lb 0x43 -> 0xFFFFFF80; lb 0x40 -> 0x00000001; lh 0x42 -> 0xFFFF80FF; lh 0x40 -> 0x00007F01; lw 0x40 -> 0x80FF7F01.
- sw of 0xCAFEF00D to 0x44 with MISALIGN_SUPPRESS=1. Required: Mem_MemWrite=1 in the same cycle, no stall. Then sh to 0x45. Required: MEM_Misaligned=1, no write, no stall, MisalignedSticky=1 after the edge.
- Two back-to-back sb stores, 0x01 to 0x48 then 0x02 to 0x4B, with word 0x48 initially 0. Required: 4 cycles total, final word 0x02000001, SubwordStoreCount=2.
- sb issued, then Reset=1 in the MERGE cycle. Required: Mem_MemWrite=0 that cycle, memory unchanged, state IDLE, count=0, sticky=0.
